// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the serial BCD subtractor.
package bcd_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned WORD_W  = DIGITS * DIGIT_W;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // True when any packed nibble is not a legal BCD digit.
  function automatic logic has_invalid(input logic [WORD_W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_sub4_serial_if.sv
// Request/result bundle for the serial BCD subtractor.
interface bcd_sub4_serial_if;
  import bcd_pkg::*;

  logic              start;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              bin;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] diff;
  logic              bout;
  logic              err;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, err
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, err
  );

endinterface

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtract with borrow: t = a - b - bin, wrapped by +10 when negative.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] digit,
  output logic               bout
);

  logic signed [DIGIT_W:0] t;

  // Signed 5-bit difference, then ten's-complement correction on underflow.
  always_comb begin
    t = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({{DIGIT_W{1'b0}}, bin});
    if (t[DIGIT_W]) begin
      digit = t[DIGIT_W-1:0] + 4'd10;
      bout  = 1'b1;
    end else begin
      digit = t[DIGIT_W-1:0];
      bout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_sub4_serial.sv
// Four-digit packed-BCD subtractor, one digit per cycle through a shared digit slice.
module bcd_sub4_serial
  import bcd_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  bcd_sub4_serial_if.slave  bus
);

  // CALC runs index 0..3 over the digits, then one commit step at index 4
  // so the result lands on diff exactly five edges after accept.
  localparam logic [IDX_W-1:0] CommitIdx = IDX_W'(DIGITS);

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WORD_W-1:0]  a_q;
  logic [WORD_W-1:0]  b_q;
  logic [WORD_W-1:0]  res_q;
  logic               borrow_q;
  logic               busy_q;
  logic               done_q;
  logic [WORD_W-1:0]  diff_q;
  logic               bout_q;
  logic               err_q;

  logic [DIGIT_W-1:0] dig;
  logic               dig_bout;

  bcd_digit_sub u_digit (
    .a     (a_q[DIGIT_W-1:0]),
    .b     (b_q[DIGIT_W-1:0]),
    .bin   (borrow_q),
    .digit (dig),
    .bout  (dig_bout)
  );

  // Control FSM with registered outputs; operands shift right so the slice
  // always sees the current digit in the low nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.bin;
            idx_q    <= '0;
            err_q    <= has_invalid(bus.a) | has_invalid(bus.b);
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (idx_q == CommitIdx) begin
            diff_q  <= err_q ? '0 : res_q;
            bout_q  <= err_q ? 1'b0 : borrow_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            res_q    <= {dig, res_q[WORD_W-1:DIGIT_W]};
            a_q      <= {{DIGIT_W{1'b0}}, a_q[WORD_W-1:DIGIT_W]};
            b_q      <= {{DIGIT_W{1'b0}}, b_q[WORD_W-1:DIGIT_W]};
            borrow_q <= dig_bout;
            idx_q    <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.err  = err_q;

endmodule
